store_buffer: RTL



---
 rtl/store_buffer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// In-order posted-write FIFO between the store alignment stage and the data
// memory bus. The core pushes aligned stores (word address, data, byte mask)
// in one cycle; entries drain to memory over a valid/ready handshake. Only
// `full` throttles the core.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   AW     word-address width (byte address bits [AW+1:2]), AW <= 30
//
// Ports:
//   clk, resetn                 clock (rising edge), async active-low reset
//   push_valid/push_ready       core store handshake
//   push_addr/wdata/wmask       store word address, lane data, byte enables
//   mem_valid/mem_ready         memory write handshake for the head entry
//   mem_addr/wdata/wstrb        head entry (byte address), zero when empty
//   count, empty, full          occupancy status
//   ld_addr, ld_hit             load forwarding hazard check
//
// Optional feature macro: STORE_BUFFER_LD_HAZARD_EN
//   defined     : ld_hit = OR over occupied entries of (entry addr == ld_addr)
//   not defined : ld_hit tied to 0, no comparators built
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [AW-1:0]              push_addr,
  input  logic [31:0]                push_wdata,
  input  logic [3:0]                 push_wmask,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wstrb,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // Entry storage is deliberately not reset; occupancy comes from count_r.
  logic [AW-1:0] addr_q_r [DEPTH];
  logic [31:0]   data_q_r [DEPTH];
  logic [3:0]    mask_q_r [DEPTH];

  logic empty_s;
  logic full_s;
  logic push_en_s;
  logic pop_en_s;

  // Occupancy flags and handshake qualifiers. A zero-mask push completes its
  // handshake but is not enqueued.
  always_comb begin
    empty_s   = (count_r == CW'(0));
    full_s    = (count_r == CW'(DEPTH));
    push_en_s = push_valid && !full_s && (push_wmask != 4'b0000);
    pop_en_s  = !empty_s && mem_ready;
  end

  assign push_ready = !full_s;
  assign mem_valid  = !empty_s;
  assign count      = count_r;
  assign empty      = empty_s;
  assign full       = full_s;

  // Head entry presented to memory; forced to zero while empty so stale
  // storage never leaks onto the bus.
  always_comb begin
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    mem_wstrb = 4'b0000;
    if (!empty_s) begin
      mem_addr[AW+1:2] = addr_q_r[rd_ptr_r];
      mem_wdata        = data_q_r[rd_ptr_r];
      mem_wstrb        = mask_q_r[rd_ptr_r];
    end else begin
      mem_addr  = 32'h0000_0000;
      mem_wdata = 32'h0000_0000;
      mem_wstrb = 4'b0000;
    end
  end

  // Pointer and occupancy state. Pointers wrap naturally at DEPTH; full and
  // empty derive from count_r rather than pointer equality.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + CW'(push_en_s) - CW'(pop_en_s);
    end
  end

  // Entry write port.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      addr_q_r[wr_ptr_r] <= push_addr;
      data_q_r[wr_ptr_r] <= push_wdata;
      mask_q_r[wr_ptr_r] <= push_wmask;
    end
  end

`ifdef STORE_BUFFER_LD_HAZARD_EN
  // Load hazard: entry i is occupied when its distance from the head is below
  // count_r. The head (even if popping this cycle) is included.
  always_comb begin
    logic [PW-1:0] off_s;
    logic          occ_s;
    ld_hit = 1'b0;
    off_s  = {PW{1'b0}};
    occ_s  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s  = PW'(i) - rd_ptr_r;
      occ_s  = (CW'(off_s) < count_r);
      ld_hit = ld_hit | (occ_s && (addr_q_r[i] == ld_addr));
    end
  end
`else
  // No forwarding check; the core drains the buffer before issuing loads.
  // ld_addr stays referenced but the expression reduces to a constant 0.
  assign ld_hit = 1'b0 & (^ld_addr);
`endif

endmodule
